// File: rtl/prog_loader.sv
// prog_loader: UART (8N1) program loader.
// The first valid byte of a load is a length L. The next L valid bytes are
// written to consecutive program-memory addresses, starting at address 0.
// Ports:
//   clk         system clock (single domain)
//   rst         asynchronous active-low reset
//   rx          UART serial line; idles high; asynchronous to clk
//   mem_we      one-cycle write strobe per loaded byte
//   mem_addr    write address; holds its last value between strobes
//   mem_data    write data; holds its last value between strobes
//   busy        a load is in progress
//   load_done   last load completed; cleared by the next length byte
//   frame_err   sticky stop-bit error; cleared by the next valid length byte
//   timeout_err sticky inter-byte timeout; cleared by the next valid length byte
module prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned TIMEOUT_CLKS = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       busy,
    output logic       load_done,
    output logic       frame_err,
    output logic       timeout_err
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned HALF_BIT = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_DATA = 1'b1
    } ld_state_e;

    // Synchronizer and falling-edge detector.
    logic sync1_q, sync2_q, rx_prev_q;
    logic rx_s;
    logic start_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx_s       = sync2_q;
    assign start_edge = rx_prev_q & ~rx_s;

    // Receiver state.
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid;   // stop sampled high; byte is in shift_q
    logic             byte_ferr;    // stop sampled low

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Receiver next state: start-bit midpoint check, then one sample per bit.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        byte_ferr  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (start_edge) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d      = '0;
                    // A high line at the midpoint was a glitch, not a start bit.
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_valid = rx_s;
                    byte_ferr  = ~rx_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Loader state.
    ld_state_e        l_state_q, l_state_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       remaining_q, remaining_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_we_q, mem_we_d;
    logic [7:0]       mem_addr_q, mem_addr_d;
    logic [7:0]       mem_data_q, mem_data_d;
    logic             busy_q, busy_d;
    logic             load_done_q, load_done_d;
    logic             frame_err_q, frame_err_d;
    logic             timeout_err_q, timeout_err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_state_q     <= L_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            tmo_cnt_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            busy_q        <= 1'b0;
            load_done_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            l_state_q     <= l_state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            busy_q        <= busy_d;
            load_done_q   <= load_done_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Loader next state. busy follows the loader state one cycle late, so it
    // drops the cycle after the final write (which is the cycle load_done rises).
    always_comb begin
        l_state_d     = l_state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        tmo_cnt_d     = '0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        busy_d        = (l_state_q == L_DATA);
        load_done_d   = load_done_q;
        frame_err_d   = frame_err_q;
        timeout_err_d = timeout_err_q;
        if (byte_ferr) begin
            frame_err_d = 1'b1;
            busy_d      = 1'b0;
            l_state_d   = L_IDLE;
        end else begin
            case (l_state_q)
                L_IDLE: begin
                    if (byte_valid) begin
                        load_done_d   = 1'b0;
                        frame_err_d   = 1'b0;
                        timeout_err_d = 1'b0;
                        addr_d        = '0;
                        if (shift_q == 8'd0) begin
                            load_done_d = 1'b1;
                        end else begin
                            busy_d      = 1'b1;
                            remaining_d = shift_q;
                            l_state_d   = L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (byte_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_data_d  = shift_q;
                        addr_d      = addr_q + 8'd1;
                        remaining_d = remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            load_done_d = 1'b1;
                            l_state_d   = L_IDLE;
                        end
                    end else if (rx_state_q == RX_IDLE && !start_edge) begin
                        // Idle time since the last stop sample.
                        if (tmo_cnt_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
                            timeout_err_d = 1'b1;
                            busy_d        = 1'b0;
                            l_state_d     = L_IDLE;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end
                default: l_state_d = L_IDLE;
            endcase
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign busy        = busy_q;
    assign load_done   = load_done_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader (16 clocks/bit, 1000-clock timeout).
module tb_prog_loader;

    localparam int unsigned BIT = 16;
    localparam int unsigned TMO = 1000;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       busy;
    logic       load_done;
    logic       frame_err;
    logic       timeout_err;

    prog_loader #(
        .CLKS_PER_BIT(BIT),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .load_done  (load_done),
        .frame_err  (frame_err),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed and expected writes, in order.
    logic [7:0] got_a[$];
    logic [7:0] got_d[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_d[$];
    logic       busy_seen;
    logic       prev_we;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Write monitor: records each strobe and checks it lasts one cycle.
    initial prev_we = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (busy) busy_seen = 1'b1;
            if (mem_we) begin
                chk("we_single_cycle", 32'(prev_we), 32'd0);
                got_a.push_back(mem_addr);
                got_d.push_back(mem_data);
            end
        end
        prev_we = mem_we;
    end

    task automatic clear_obs();
        got_a.delete();
        got_d.delete();
        exp_a.delete();
        exp_d.delete();
        busy_seen = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_gap(input logic [7:0] b, input logic stop_ok);
        send_byte(b, stop_ok);
        repeat (3) @(negedge clk);
    endtask

    task automatic cmp_writes(input string tag);
        chk($sformatf("%s.nwrites", tag), 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), 32'(got_a[i]), 32'(exp_a[i]));
            chk($sformatf("%s.data%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
        end
    endtask

    task automatic cmp_flags(input string tag, input logic ld, input logic bz,
                             input logic fe, input logic te);
        chk($sformatf("%s.load_done", tag), 32'(load_done), 32'(ld));
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(bz));
        chk($sformatf("%s.frame_err", tag), 32'(frame_err), 32'(fe));
        chk($sformatf("%s.timeout_err", tag), 32'(timeout_err), 32'(te));
    endtask

    task automatic cmp_all_zero(input string tag);
        chk($sformatf("%s.mem_we", tag), 32'(mem_we), 32'd0);
        chk($sformatf("%s.mem_addr", tag), 32'(mem_addr), 32'd0);
        chk($sformatf("%s.mem_data", tag), 32'(mem_data), 32'd0);
        cmp_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Directed vectors: frames with stop-bit validity, expected writes and flags.
    typedef struct packed {
        logic [2:0]      n;
        logic [4:0][7:0] b;
        logic [4:0]      so;
        logic [2:0]      nw;
        logic [3:0][7:0] wa;
        logic [3:0][7:0] wd;
        logic            ld;
        logic            bz;
        logic            fe;
        logic            te;
        logic            bs;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [39:0] b, input logic [4:0] so,
                                input int nw, input logic [31:0] wa, input logic [31:0] wd,
                                input logic ld, input logic bz, input logic fe,
                                input logic te, input logic bs);
        vec_t v;
        v.n  = 3'(n);
        v.b  = b;
        v.so = so;
        v.nw = 3'(nw);
        v.wa = wa;
        v.wd = wd;
        v.ld = ld;
        v.bz = bz;
        v.fe = fe;
        v.te = te;
        v.bs = bs;
        return v;
    endfunction

    // Reference loader model, applied frame by frame.
    logic       m_loading;
    logic [8:0] m_rem;
    logic [7:0] m_addr;
    logic       m_ld, m_fe, m_te;

    task automatic model_frame(input logic [7:0] b, input logic ok);
        if (!ok) begin
            m_fe      = 1'b1;
            m_loading = 1'b0;
        end else if (!m_loading) begin
            m_ld   = 1'b0;
            m_fe   = 1'b0;
            m_te   = 1'b0;
            m_addr = 8'd0;
            if (b == 8'd0) begin
                m_ld = 1'b1;
            end else begin
                m_loading = 1'b1;
                m_rem     = 9'(b);
            end
        end else begin
            exp_a.push_back(m_addr);
            exp_d.push_back(b);
            m_addr = m_addr + 8'd1;
            m_rem  = m_rem - 9'd1;
            if (m_rem == 9'd0) begin
                m_ld      = 1'b1;
                m_loading = 1'b0;
            end
        end
    endtask

    vec_t       vecs[6];
    vec_t       v;
    logic [7:0] rb;
    logic       rok;
    int         nfr;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        busy_seen = 1'b0;
        #1 rst = 1'b0;
        #1 cmp_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        vecs[0] = mk(4, {8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h03}, 5'b01111, 3,
                     {8'h00, 8'h02, 8'h01, 8'h00}, {8'h00, 8'hC3, 8'hB2, 8'hA1}, 1, 0, 0, 0, 1);
        vecs[1] = mk(1, {32'h0, 8'h00}, 5'b00001, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
        vecs[2] = mk(3, {16'h0, 8'h22, 8'h11, 8'h02}, 5'b00011, 1,
                     32'h0, {24'h0, 8'h11}, 0, 0, 1, 0, 1);
        vecs[3] = mk(2, {24'h0, 8'hEE, 8'h01}, 5'b00011, 1,
                     32'h0, {24'h0, 8'hEE}, 1, 0, 0, 0, 1);
        vecs[4] = mk(1, {32'h0, 8'hFF}, 5'b00000, 0, 32'h0, 32'h0, 1, 0, 1, 0, 0);
        vecs[5] = mk(3, {16'h0, 8'hA5, 8'h5A, 8'h02}, 5'b00111, 2,
                     {16'h0, 8'h01, 8'h00}, {16'h0, 8'hA5, 8'h5A}, 1, 0, 0, 0, 1);

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            clear_obs();
            for (int i = 0; i < int'(v.nw); i++) begin
                exp_a.push_back(v.wa[i]);
                exp_d.push_back(v.wd[i]);
            end
            for (int f = 0; f < int'(v.n); f++) send_gap(v.b[f], v.so[f]);
            repeat (20) @(negedge clk);
            cmp_writes($sformatf("vec%0d", k));
            cmp_flags($sformatf("vec%0d", k), v.ld, v.bz, v.fe, v.te);
            chk($sformatf("vec%0d.busy_seen", k), 32'(busy_seen), 32'(v.bs));
        end

        // Short low pulse must not decode as a byte.
        clear_obs();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        cmp_writes("glitch");
        cmp_flags("glitch", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("glitch.busy_seen", 32'(busy_seen), 32'd0);
        clear_obs();
        exp_a.push_back(8'h00);
        exp_d.push_back(8'h9C);
        send_gap(8'h01, 1'b1);
        send_gap(8'h9C, 1'b1);
        repeat (20) @(negedge clk);
        cmp_writes("post_glitch");
        cmp_flags("post_glitch", 1'b1, 1'b0, 1'b0, 1'b0);

        // Inter-byte timeout mid-load, then recovery.
        clear_obs();
        exp_a.push_back(8'h00);
        exp_d.push_back(8'h55);
        send_gap(8'h02, 1'b1);
        send_gap(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        cmp_flags("pre_timeout", 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (1180) @(negedge clk);
        cmp_writes("timeout");
        cmp_flags("timeout", 1'b0, 1'b0, 1'b0, 1'b1);
        clear_obs();
        exp_a.push_back(8'h00);
        exp_d.push_back(8'h77);
        send_gap(8'h01, 1'b1);
        send_gap(8'h77, 1'b1);
        repeat (20) @(negedge clk);
        cmp_writes("post_timeout");
        cmp_flags("post_timeout", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 3 of the second byte.
        clear_obs();
        send_gap(8'h02, 1'b1);
        rb = 8'h5D;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = rb[i];
            repeat (BIT) @(negedge clk);
        end
        rx = rb[3];
        repeat (BIT / 2) @(negedge clk);
        chk("pre_reset.busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1 cmp_all_zero("mid_reset");
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        exp_a.push_back(8'h00);
        exp_d.push_back(8'h42);
        send_gap(8'h01, 1'b1);
        send_gap(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        cmp_writes("post_reset");
        cmp_flags("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized frame sequences against the reference model.
        m_loading = 1'b0;
        m_rem     = 9'd0;
        m_addr    = 8'd0;
        m_ld      = 1'b1;
        m_fe      = 1'b0;
        m_te      = 1'b0;
        for (int r = 0; r < 8; r++) begin
            clear_obs();
            nfr = int'($urandom_range(1, 5));
            for (int f = 0; f < nfr; f++) begin
                if (f == 0) begin
                    rb  = 8'($urandom_range(0, 4));
                    rok = 1'b1;
                end else begin
                    rb  = 8'($urandom);
                    rok = ($urandom_range(0, 7) != 0);
                end
                send_byte(rb, rok);
                model_frame(rb, rok);
                repeat (3 + int'($urandom_range(0, 40))) @(negedge clk);
            end
            repeat (1200) @(negedge clk);
            if (m_loading) begin
                m_te      = 1'b1;
                m_loading = 1'b0;
            end
            cmp_writes($sformatf("rnd%0d", r));
            cmp_flags($sformatf("rnd%0d", r), m_ld, 1'b0, m_fe, m_te);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clocks per UART bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 2_000_000, meaning the inter-byte timeout while loading.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain only.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  UART serial line; idles high; asynchronous to clk.
REQ-006 SHALL have port mem_we  output  1  program-memory write strobe, one cycle per byte.
REQ-007 SHALL have port mem_addr  output  8  program-memory write address.
REQ-008 SHALL have port mem_data  output  8  program-memory write data.
REQ-009 SHALL have port busy  output  1  high while a load is in progress.
REQ-010 SHALL have port load_done  output  1  level; high after a complete load until the next length byte.
REQ-011 SHALL have port frame_err  output  1  sticky; set on a stop-bit error; cleared by reset or by the next valid length byte.
REQ-012 SHALL have port timeout_err  output  1  sticky; cleared under the same conditions as frame_err.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all rx decisions use the synchronized value.
REQ-014 SHALL run the receiver FSM RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
REQ-015 SHALL enter RX_START on a high-to-low transition of the synchronized rx, with the bit counter cleared.
REQ-016 In RX_START, SHALL resample at CLKS_PER_BIT/2 (integer division); if rx is high, treat it as a glitch, return to RX_IDLE, and emit no byte.
REQ-017 SHALL sample the 8 data bits, LSB first, at CLKS_PER_BIT intervals from the start-bit midpoint.
REQ-018 SHALL sample the stop bit one CLKS_PER_BIT after data bit 7; stop high = valid byte, stop low = framing error.
REQ-019 SHALL rearm for a new falling edge immediately after the stop sample; no extra idle time is required.
REQ-020 SHALL run the loader FSM L_IDLE -> L_DATA -> L_IDLE, driven by valid bytes.
REQ-021 In L_IDLE, a valid byte SHALL be the length L: clear load_done, frame_err, timeout_err and the address counter.
REQ-022 In L_IDLE with L=0, SHALL set load_done next cycle, keep busy low, and perform no writes.
REQ-023 In L_IDLE with L>0, SHALL set busy next cycle and go to L_DATA with remaining=L.
REQ-024 In L_DATA, each valid byte SHALL produce mem_we=1 for exactly one cycle, the cycle after the stop sample, with mem_addr=counter and mem_data=byte; then increment the counter and decrement remaining.
REQ-025 When remaining reaches 0, SHALL (same cycle as the last mem_we) set load_done, and go to L_IDLE; busy SHALL drop the following cycle.
REQ-026 The address counter SHALL be 8 bits; L<=255, so no wrap occurs within a load.
REQ-027 A framing error in any loader state SHALL set frame_err, write nothing, clear busy, and return to L_IDLE; a framing error on the length byte leaves load_done unchanged.
REQ-028 In L_DATA, if no start edge is seen for TIMEOUT_CLKS cycles after the previous stop sample, SHALL set timeout_err, clear busy, and return to L_IDLE.
REQ-029 Outside mem_we cycles, mem_addr and mem_data SHALL hold their last driven values.
REQ-030 A new length byte after load_done SHALL start a fresh load at address 0.

Reset
REQ-031 On rst=0, SHALL clear all state asynchronously: both FSMs idle, counters 0, mem_we=0, mem_addr=0, mem_data=0, busy=0, load_done=0, frame_err=0, timeout_err=0; synchronizer flops load 1.
REQ-032 Reset asserted mid-byte or mid-load SHALL abandon it; after release, a complete new length byte is required.

Verification (bench: CLKS_PER_BIT=16, TIMEOUT_CLKS=1000)
REQ-033 Send 0x03, 0xA1, 0xB2, 0xC3 -> writes (0x00,0xA1), (0x01,0xB2), (0x02,0xC3), each mem_we 1 cycle; load_done=1; busy=0.
REQ-034 Send 0x00 -> no mem_we; load_done=1; busy never high.
REQ-035 Send 0x02, 0x11, then 0x22 with stop bit 0 -> single write (0x00,0x11); frame_err=1; busy=0; load_done=0.
REQ-036 Send 0x02, 0x55, then idle for 1200 clocks -> single write (0x00,0x55); timeout_err=1; busy=0; a following 0x01, 0x77 writes (0x00,0x77) and clears timeout_err.
REQ-037 Hold rx low for 4 clocks only -> no byte decoded, no state change; then 0x01, 0x9C -> write (0x00,0x9C).
REQ-038 Pull rst low during data bit 3 of the second byte -> all outputs 0 immediately; a subsequent 0x01, 0x42 writes (0x00,0x42).
